multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM that runs the impostor_32 RV32I datapath as a multi-cycle machine over one shared,
//  variable-latency memory. It replaces the single-cycle maincontroller: it steps each instruction
//  through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file, memory and mux strobes.
//  It traps on illegal opcodes and on memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may stay high without mem_ready before the FSM traps (>=2)
// PORTS
//  clk          in   1  system clock; all state updates on the rising edge
//  reset        in   1  synchronous, active-high reset
//  opcode       in   7  instr[6:0] from IR; valid from DECODE onward
//  zero         in   1  ALU branch-condition-met flag; sampled in EXEC
//  mem_ready    in   1  memory done; may assert in the same cycle as mem_req (zero wait)
//  mem_req      out  1  memory access request; held until mem_ready
//  iord         out  1  memory address select: 0 = PC (fetch), 1 = ALU_result (data)
//  mem_read     out  1  read access
//  mem_write    out  1  write access (STORE only)
//  ir_write     out  1  load IR; pulses in the FETCH cycle where mem_ready=1
//  pc_write     out  1  load PC; one pulse per instruction
//  pc_src       out  2  PC source: 00 pc_plus4, 01 branch_out, 10 alu_out (JALR)
//  reg_write    out  1  register-file write strobe
//  mem_reg      out  1  write-back source: 0 = ALU_result, 1 = read_data
//  J_type       out  1  write-back pc_plus4 (JAL/JALR)
//  ALUsrc       out  1  ALU B source: 0 = read_data_2, 1 = immidiate
//  ALU_op       out  2  to alu_control: 00 add, 01 branch compare, 10 R funct, 11 I funct
//  ALU_En       out  1  ALU enable
//  branch       out  1  branch instruction in EXEC
//  instr_done   out  1  one-cycle pulse in the final cycle of each instruction
//  fault        out  1  sticky; high in TRAP
//  fault_code   out  2  01 illegal opcode, 10 fetch timeout, 11 data timeout; 00 otherwise
// BEHAVIOUR
//  - Reset: while reset=1, state<=FETCH, op_q<=0, wait_cnt<=0, fault_code<=0, and every output is
//    forced to 0. The first cycle after release is FETCH. A reset mid-instruction abandons the
//    instruction; no pc_write, reg_write or mem_write is issued in the reset cycle.
//  - Output timing: outputs are combinational from the registered state, op_q and the current inputs.
//  - FETCH: mem_req=1, mem_read=1, iord=0. On mem_ready: ir_write=1, go to DECODE.
//  - DECODE: op_q<=opcode.
//    - 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL and
//      1100111 JALR go to EXEC.
//    - Any other opcode goes to TRAP with code 01.
//  - EXEC: ALU_En=1, with ALU_op/ALUsrc per op_q.
//    - ALUsrc=1 for I, LOAD, STORE, JALR.
//    - BRANCH: branch=1, pc_write=1, pc_src=01 if zero else 00, instr_done=1, then FETCH.
//    - LOAD/STORE go to MEM. R, I, JAL and JALR go to WB.
//  - MEM: ALU_En=1, mem_req=1, iord=1; mem_read=1 for LOAD, mem_write=1 for STORE.
//    - On mem_ready, LOAD goes to WB.
//    - On mem_ready, STORE does pc_write=1, pc_src=00, instr_done=1, then FETCH.
//  - WB: reg_write=1, pc_write=1, instr_done=1, then FETCH.
//    - LOAD: mem_reg=1.
//    - JAL/JALR: J_type=1; pc_src=01 for JAL, 10 for JALR.
//    - All other ops: pc_src=00.
//  - Latency with zero-wait memory: BRANCH 3 cycles, R/I/STORE/JAL/JALR 4, LOAD 5.
//    Each wait cycle adds 1.
//  - Timeout:
//    - wait_cnt increments each cycle in FETCH/MEM with mem_ready=0 and clears on state exit.
//    - When wait_cnt==MEM_TIMEOUT-1 and mem_ready=0, go to TRAP: code 10 from FETCH, 11 from MEM.
//    - mem_ready in the same cycle as the limit wins; the access completes normally.
//  - TRAP: all strobes 0, fault=1, fault_code held. Only reset exits.
// STRUCTURE
//  - impostor_pkg: state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP); opcode localparams;
//    ALU_op, pc_src and fault_code encodings.
//  - Sub-module mem_wait_timer: the wait_cnt counter plus the expire flag, parameterised by
//    MEM_TIMEOUT; instantiated once.
// TESTING
//  1 Reset held 3 cycles, then released with mem_ready=1 -> outputs 0 during reset; cycle 1 after
//    release has mem_req=1, iord=0, ir_write=1.
//  2 R-type (opcode 0110011), zero-wait memory -> 4 cycles; WB has reg_write=1, pc_write=1,
//    pc_src=00, ALU_op=10, ALUsrc=0.
//  3 LOAD with mem_ready delayed 3 cycles in MEM -> instruction takes 8 cycles; WB has mem_reg=1;
//    mem_write never asserts.
//  4 BRANCH, zero=1 then zero=0 -> 3 cycles each; pc_src=01, then 00; reg_write never asserts.
//  5 JALR -> WB has J_type=1, pc_src=10, reg_write=1. Opcode 1111111 -> TRAP, fault_code=01,
//    no pc_write.
//  6 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, fault_code=10.
//    Ready on cycle 4 -> no trap. Reset in TRAP -> FETCH.

Source files
------------

// File: rtl/impostor_pkg.sv
// Shared types and encodings for the impostor_32 multi-cycle control path.
package impostor_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RF    = 2'b10;
  localparam logic [1:0] ALU_IF    = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_FETCH_TO = 2'b10;
  localparam logic [1:0] FC_DATA_TO  = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JALR);
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [6:0] op);
    case (op)
      OP_R:      return ALU_RF;
      OP_I:      return ALU_IF;
      OP_BRANCH: return ALU_BR;
      default:   return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// in which the access must be abandoned.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] wait_cnt;

  // Ready in the limit cycle completes the access, so it masks expiry.
  assign expire = active && !ready && (wait_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset || !active || ready || expire)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the impostor_32 RV32I datapath over a shared,
// variable-latency memory; traps on illegal opcodes and memory timeouts.
module multicycle_controller
  import impostor_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       mem_reg,
  output logic       J_type,
  output logic       ALUsrc,
  output logic [1:0] ALU_op,
  output logic       ALU_En,
  output logic       branch,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  state_t     state, state_next;
  logic [6:0] op_q;
  logic [1:0] fc_q, fc_next;
  logic       expire;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .active ((state == FETCH) || (state == MEM)),
    .ready  (mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
      fc_q  <= FC_NONE;
    end else begin
      state <= state_next;
      fc_q  <= fc_next;
      if (state == DECODE)
        op_q <= opcode;
    end
  end

  always_comb begin
    state_next = state;
    fc_next    = fc_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    mem_reg    = 1'b0;
    J_type     = 1'b0;
    ALUsrc     = 1'b0;
    ALU_op     = ALU_ADD;
    ALU_En     = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    fault_code = fc_q;

    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end else if (expire) begin
          state_next = TRAP;
          fc_next    = FC_FETCH_TO;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_next = EXEC;
        end else begin
          state_next = TRAP;
          fc_next    = FC_ILLEGAL;
        end
      end
      EXEC: begin
        ALU_En = 1'b1;
        ALUsrc = uses_imm(op_q);
        ALU_op = alu_op_for(op_q);
        if (op_q == OP_BRANCH) begin
          branch     = 1'b1;
          pc_write   = 1'b1;
          pc_src     = zero ? PC_BRANCH : PC_PLUS4;
          instr_done = 1'b1;
          state_next = FETCH;
        end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        // ALU stays enabled so the data address remains valid across wait cycles.
        ALU_En    = 1'b1;
        ALUsrc    = uses_imm(op_q);
        ALU_op    = alu_op_for(op_q);
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (expire) begin
          state_next = TRAP;
          fc_next    = FC_DATA_TO;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        mem_reg    = (op_q == OP_LOAD);
        state_next = FETCH;
        if (op_q == OP_JAL) begin
          J_type = 1'b1;
          pc_src = PC_BRANCH;
        end else if (op_q == OP_JALR) begin
          J_type = 1'b1;
          pc_src = PC_ALU;
        end
      end
      TRAP: begin
        fault = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      reg_write  = 1'b0;
      mem_reg    = 1'b0;
      J_type     = 1'b0;
      ALUsrc     = 1'b0;
      ALU_op     = ALU_ADD;
      ALU_En     = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      fault      = 1'b0;
      fault_code = FC_NONE;
    end
  end

endmodule
